// File: rtl/rc4_pkg.sv
// Shared types for the RC4 key-schedule engine: state encoding and data width.
package rc4_pkg;
  localparam int DATA_W = 8;

  // One-hot so a single corrupted flop is visible as an illegal state.
  typedef enum logic [9:0] {
    IDLE   = 10'b00_0000_0001,
    RD_I   = 10'b00_0000_0010,
    WAIT_I = 10'b00_0000_0100,
    CALC_J = 10'b00_0000_1000,
    RD_J   = 10'b00_0001_0000,
    WAIT_J = 10'b00_0010_0000,
    WR_J   = 10'b00_0100_0000,
    WR_I   = 10'b00_1000_0000,
    NEXT   = 10'b01_0000_0000,
    DONE   = 10'b10_0000_0000
  } state_t;
endpackage

// File: rtl/rc4_ksa_engine_if.sv
// S-memory port of the key-schedule engine: single address, separate read/write strobes.
interface rc4_ksa_engine_if import rc4_pkg::*; #(
  parameter int ADDR_W = 8
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rden;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_addr, mem_wdata, mem_rden, mem_wren, input mem_rdata);
  modport slave  (input mem_addr, mem_wdata, mem_rden, mem_wren, output mem_rdata);
endinterface

// File: rtl/rc4_key_byte_sel.sv
// Picks key byte idx from a MSB-first packed key (byte 0 in the top lane).
module rc4_key_byte_sel import rc4_pkg::*; #(
  parameter int KEY_BYTES = 3,
  parameter int IDX_W     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
  input  logic [KEY_BYTES-1:0][DATA_W-1:0] key,
  input  logic [IDX_W-1:0]                 idx,
  output logic [DATA_W-1:0]                key_byte
);
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++)
      if (idx == IDX_W'(b)) key_byte = key[KEY_BYTES-1-b];
  end
endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine driving an external S-box memory with fixed read latency.
module rc4_ksa_engine import rc4_pkg::*; #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3,
  parameter int RD_LAT    = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [8*KEY_BYTES-1:0]           key,
  input  logic [$clog2(KEY_BYTES+1)-1:0]   key_len,
  rc4_ksa_engine_if.master                 mem,
  output logic                             busy,
  output logic                             done,
  output logic                             aborted
);
  localparam int LEN_W = $clog2(KEY_BYTES+1);
  localparam int IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int WC_W  = 2;

  state_t                          state, state_n;
  logic [ADDR_W-1:0]               i, i_n, j, j_n;
  logic [DATA_W-1:0]               si, si_n, sj, sj_n;
  logic [IDX_W-1:0]                kidx, kidx_n, last_idx, last_n;
  logic [WC_W-1:0]                 wcnt, wcnt_n;
  logic [KEY_BYTES-1:0][DATA_W-1:0] key_r, key_n;
  logic [DATA_W-1:0]               kbyte;

  logic [ADDR_W-1:0]               addr_q, addr_n;
  logic [DATA_W-1:0]               wdata_q, wdata_n;
  logic                            rden_q, rden_n, wren_q, wren_n;
  logic                            busy_n, done_n, aborted_n;

  rc4_key_byte_sel #(.KEY_BYTES(KEY_BYTES), .IDX_W(IDX_W)) u_ksel (
    .key      (key_r),
    .idx      (kidx),
    .key_byte (kbyte)
  );

  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    si_n    = si;
    sj_n    = sj;
    kidx_n  = kidx;
    last_n  = last_idx;
    key_n   = key_r;
    wcnt_n  = wcnt;
    case (state)
      IDLE: if (start && !abort) begin
        state_n = RD_I;
        i_n     = '0;
        j_n     = '0;
        kidx_n  = '0;
        key_n   = key;
        // Out-of-range lengths fall back to the full key.
        if (key_len == '0 || key_len > LEN_W'(KEY_BYTES)) last_n = IDX_W'(KEY_BYTES-1);
        else                                              last_n = IDX_W'(key_len - LEN_W'(1));
      end
      RD_I: begin
        state_n = WAIT_I;
        wcnt_n  = WC_W'(RD_LAT-1);
      end
      WAIT_I: begin
        if (wcnt == '0) begin
          si_n    = mem.mem_rdata;
          state_n = CALC_J;
        end else wcnt_n = wcnt - WC_W'(1);
      end
      CALC_J: begin
        j_n     = j + si[ADDR_W-1:0] + kbyte[ADDR_W-1:0];
        state_n = RD_J;
      end
      RD_J: begin
        state_n = WAIT_J;
        wcnt_n  = WC_W'(RD_LAT-1);
      end
      WAIT_J: begin
        if (wcnt == '0) begin
          sj_n    = mem.mem_rdata;
          state_n = WR_J;
        end else wcnt_n = wcnt - WC_W'(1);
      end
      WR_J: state_n = WR_I;
      WR_I: state_n = NEXT;
      NEXT: begin
        if (i == {ADDR_W{1'b1}}) state_n = DONE;
        else begin
          i_n     = i + ADDR_W'(1);
          kidx_n  = (kidx == last_idx) ? '0 : kidx + IDX_W'(1);
          state_n = RD_I;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state != IDLE && abort) state_n = IDLE;

    // Outputs are computed from the next state so they register alongside it.
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    rden_n    = 1'b0;
    wren_n    = 1'b0;
    case (state_n)
      RD_I: begin addr_n = i_n; rden_n = 1'b1; end
      RD_J: begin addr_n = j_n; rden_n = 1'b1; end
      WR_J: begin addr_n = j_n; wdata_n = si_n; wren_n = 1'b1; end
      WR_I: begin addr_n = i_n; wdata_n = sj_n; wren_n = 1'b1; end
      default: ;
    endcase
    busy_n    = (state_n != IDLE);
    done_n    = (state_n == DONE);
    aborted_n = (state != IDLE) && abort;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      si       <= '0;
      sj       <= '0;
      kidx     <= '0;
      last_idx <= '0;
      key_r    <= '0;
      wcnt     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rden_q   <= 1'b0;
      wren_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      state    <= state_n;
      i        <= i_n;
      j        <= j_n;
      si       <= si_n;
      sj       <= sj_n;
      kidx     <= kidx_n;
      last_idx <= last_n;
      key_r    <= key_n;
      wcnt     <= wcnt_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      rden_q   <= rden_n;
      wren_q   <= wren_n;
      busy     <= busy_n;
      done     <= done_n;
      aborted  <= aborted_n;
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_rden  = rden_q;
  assign mem.mem_wren  = wren_q;
endmodule

// File: doc/rc4_ksa_engine.md
RC4_KSA_ENGINE -- requirements
Module: rc4_ksa_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, S-box address width; depth N = 2**ADDR_W (legal 2..8).
REQ-002 SHALL have parameter KEY_BYTES, default 3, maximum key length in bytes (legal 1..32).
REQ-003 SHALL have parameter RD_LAT, default 2, S-memory read latency in cycles (legal 1..4).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin key schedule; sampled only in IDLE.
REQ-007 abort  input  1  terminate a running schedule.
REQ-008 key  input  8*KEY_BYTES  secret key; byte 0 = key[8*KEY_BYTES-1 -: 8] (MSB first).
REQ-009 key_len  input  $clog2(KEY_BYTES+1)  active key length in bytes.
REQ-010 mem_addr  output  ADDR_W  S-memory address.
REQ-011 mem_wdata  output  8  S-memory write data.
REQ-012 mem_rden  output  1  read enable.
REQ-013 mem_wren  output  1  write enable.
REQ-014 mem_rdata  input  8  read data, valid RD_LAT cycles after the mem_rden cycle.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on normal completion.
REQ-017 aborted  output  1  one-cycle pulse on abort.

Function
REQ-018 SHALL perform RC4 KSA: for i = 0..N-1: j = j + S[i] + key[i mod L]; swap S[i], S[j]; S is pre-initialised externally.
REQ-019 SHALL register key and L at start; L = key_len, except key_len 0 or > KEY_BYTES gives L = KEY_BYTES.
REQ-020 SHALL derive the key index from a counter wrapping L-1 -> 0; no divider.
REQ-021 SHALL clear i and j to 0 at start; j sum is truncated to ADDR_W bits.
REQ-022 SHALL use states IDLE, RD_I, WAIT_I, CALC_J, RD_J, WAIT_J, WR_J, WR_I, NEXT, DONE; all outputs registered (Moore).
REQ-023 IDLE: start=1 and abort=0 -> RD_I; otherwise remain in IDLE.
REQ-024 RD_I: mem_addr = i, mem_rden = 1, 1 cycle; WAIT_I: RD_LAT cycles, then capture si = mem_rdata.
REQ-025 CALC_J: update j, 1 cycle; RD_J: mem_addr = j, mem_rden = 1; WAIT_J: RD_LAT cycles, then capture sj.
REQ-026 WR_J: mem_addr = j, mem_wdata = si, mem_wren = 1; WR_I: mem_addr = i, mem_wdata = sj, mem_wren = 1.
REQ-027 NEXT: if i = N-1 -> DONE; else i + 1, advance key index -> RD_I.
REQ-028 Iteration SHALL take exactly 6 + 2*RD_LAT cycles; done SHALL be high N*(6+2*RD_LAT)+1 cycles after the start-sampling edge; DONE -> IDLE.
REQ-029 When i = j, both writes SHALL occur with equal data and leave S unchanged.
REQ-030 mem_rden and mem_wren SHALL never be high in the same cycle.
REQ-031 abort in any non-IDLE state SHALL force IDLE next cycle, mem_wren/mem_rden low, pulse aborted; no further write.
REQ-032 abort SHALL take priority over start; start SHALL be ignored while busy.

Reset
REQ-033 Reset SHALL force IDLE; i, j, key index, mem_addr and mem_wdata = 0; mem_rden, mem_wren, busy, done and aborted = 0.
REQ-034 Reset mid-schedule SHALL abandon the run without an aborted pulse; the next start SHALL restart from i = 0.

Structure
REQ-035 rc4_pkg SHALL hold the state enum typedef and DATA_W = 8.
REQ-036 Key byte selection SHALL be sub-module rc4_key_byte_sel, parametrised by KEY_BYTES.

Verification
REQ-037 Defaults, identity S, key 24'h000000: done after 2561 cycles; S matches golden KSA; S[0] unchanged.
REQ-038 Defaults, key 24'h0003FF, key_len 2: S matches golden KSA with key {00,03}; byte 2 unused.
REQ-039 ADDR_W=4, KEY_BYTES=5, RD_LAT=1: 16-entry S, 5-byte key; done at cycle 129; S matches golden model.
REQ-040 abort during iteration 100: busy low next cycle; one aborted pulse; no mem_wren afterward; restart matches REQ-037.
REQ-041 start pulsed at iteration 50: ignored and final S unchanged; reset at iteration 50: all outputs 0 and restart is correct.
REQ-042 Assertions on every cycle: one-hot state; no simultaneous mem_rden and mem_wren; done and aborted never both high.
